// File: rtl/rsa_pkg.sv
// Shared constants for the RSA key path: default datapath width, key bundle field widths
// and the private-exponent FSM state encoding.
package rsa_pkg;

  localparam int RSA_W     = 24;
  localparam int KEY_E_W   = RSA_W;
  localparam int KEY_TOT_W = RSA_W;
  localparam int KEY_N_W   = RSA_W;
  localparam int KEY_D_W   = RSA_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_DIV   = 3'd2,
    ST_UPD   = 3'd3,
    ST_FIN   = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

endpackage

// File: rtl/rsa_div_seq.sv
// Restoring divider, one quotient bit per cycle; done pulses W cycles after start.
// No backpressure: start is only issued while idle and results hold until the next start.
module rsa_div_seq
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;

  // quotient doubles as the dividend shift register; its MSB feeds the partial remainder
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                              input logic [W-1:0] quo,
                                              input logic [W-1:0] dv);
    logic [W:0] sh;
    logic       ge;
    sh = {rem, quo[W-1]};
    ge = (sh >= {1'b0, dv});
    if (ge) sh = sh - {1'b0, dv};
    return {sh[W-1:0], quo[W-2:0], ge};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      dvs       <= '0;
      cnt       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {remainder, quotient} <= div_step('0, dividend, divisor);
        dvs                   <= divisor;
        cnt                   <= CW'(W - 1);
      end else if (cnt != '0) begin
        {remainder, quotient} <= div_step(remainder, quotient, dvs);
        cnt                   <= cnt - CW'(1);
        done                  <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/rsa_priv_key_gen.sv
// Computes d = e^-1 mod totient by extended Euclid; (W+3) cycles per iteration plus 3.
// Accepts one key only in IDLE; result is held until out_ready, then returns to IDLE.
module rsa_priv_key_gen
  import rsa_pkg::*;
#(
  parameter int W     = RSA_W,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [W-1:0] key_e,
  input  logic [W-1:0] key_tot,
  input  logic [W-1:0] key_n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_d,
  output logic [W-1:0] out_n,
  output logic         out_err,
  output logic         busy
);

  state_t           state;
  logic [W-1:0]     r0, r1, qt;
  logic [W:0]       t0, t1;
  logic [CNT_W-1:0] iter;
  logic [W-1:0]     tot_q, n_q;
  logic             err;

  logic             div_start;
  logic [W-1:0]     div_quo, div_rem;
  logic             div_done;

  logic [W:0]       t_prod;
  logic [W-1:0]     d_pos;

  rsa_div_seq #(.W(W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (r0),
    .divisor  (r1),
    .quotient (div_quo),
    .remainder(div_rem),
    .done     (div_done)
  );

  // t arithmetic wraps at W+1 bits; |t| <= totient keeps it exact
  assign t_prod = {1'b0, qt} * t1;
  assign d_pos  = t0[W] ? (t0[W-1:0] + tot_q) : t0[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      key_ready <= 1'b1;
      out_valid <= 1'b0;
      out_d     <= '0;
      out_n     <= '0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
      r0        <= '0;
      r1        <= '0;
      qt        <= '0;
      t0        <= '0;
      t1        <= '0;
      iter      <= '0;
      tot_q     <= '0;
      n_q       <= '0;
      err       <= 1'b0;
      div_start <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_valid) begin
            r0        <= key_tot;
            r1        <= key_e;
            t0        <= '0;
            t1        <= (W+1)'(1);
            iter      <= '0;
            tot_q     <= key_tot;
            n_q       <= key_n;
            busy      <= 1'b1;
            key_ready <= 1'b0;
            if ((key_tot < W'(2)) || (key_e == '0)) begin
              err   <= 1'b1;
              state <= ST_FIN;
            end else begin
              err   <= 1'b0;
              state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (r1 == '0) begin
            state <= ST_FIN;
          end else if (&iter) begin
            err   <= 1'b1;
            state <= ST_FIN;
          end else begin
            div_start <= 1'b1;
            state     <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            qt    <= div_quo;
            state <= ST_UPD;
          end
        end
        ST_UPD: begin
          r0    <= r1;
          r1    <= div_rem;
          t0    <= t1;
          t1    <= t0 - t_prod;
          iter  <= iter + CNT_W'(1);
          state <= ST_CHECK;
        end
        ST_FIN: begin
          out_valid <= 1'b1;
          out_n     <= n_q;
          if (err || (r0 != W'(1))) begin
            out_err <= 1'b1;
            out_d   <= '0;
          end else begin
            out_err <= 1'b0;
            out_d   <= d_pos;
          end
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            key_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_priv_key_gen.sv
// Randomized and directed checks of rsa_priv_key_gen against an integer extended-Euclid model.
module tb_rsa_priv_key_gen;
  localparam int W     = 24;
  localparam int CNT_W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [W-1:0] key_e = '0, key_tot = '0, key_n = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_d, out_n;
  logic         out_err;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  rsa_priv_key_gen #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready),
    .key_e(key_e), .key_tot(key_tot), .key_n(key_n),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_n(out_n), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Textbook extended Euclid on plain integers; lat counts edges from the IDLE cycle to out_valid
  function automatic void ref_key(input longint e, input longint tot,
                                  output longint d, output bit err, output int lat);
    longint r0, r1, t0, t1, q, tmp;
    int it;
    err = 1'b0; d = 0; it = 0;
    if (tot < 2 || e == 0) begin
      err = 1'b1; lat = 2;
      return;
    end
    r0 = tot; r1 = e; t0 = 0; t1 = 1;
    while (r1 != 0) begin
      if (it == (1 << CNT_W) - 1) begin err = 1'b1; break; end
      q   = r0 / r1;
      tmp = r0 - q * r1; r0 = r1; r1 = tmp;
      tmp = t0 - q * t1; t0 = t1; t1 = tmp;
      it++;
    end
    lat = 3 + it * (W + 3);
    if (err || r0 != 1) begin err = 1'b1; d = 0; end
    else d = (t0 < 0) ? t0 + tot : t0;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!key_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!key_ready) check("key_ready_wait", 0, 1);
  endtask

  task automatic run_key(input logic [W-1:0] e, input logic [W-1:0] tot,
                         input logic [W-1:0] n, input int hold);
    longint exp_d; bit exp_err; int exp_lat;
    int cyc;
    bit stable;
    logic [W-1:0] d_s, n_s; logic err_s;
    ref_key(longint'(e), longint'(tot), exp_d, exp_err, exp_lat);
    wait_ready();
    key_e = e; key_tot = tot; key_n = n; key_valid = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) begin key_valid = 1'b0; key_e = '0; key_tot = '0; key_n = '0; end
    end while (!out_valid && cyc < 2000);
    if (!out_valid) begin
      check($sformatf("timeout e=%0d tot=%0d", e, tot), 0, 1);
      return;
    end
    check($sformatf("lat e=%0d tot=%0d", e, tot), cyc, exp_lat);
    check($sformatf("d e=%0d tot=%0d", e, tot), out_d, exp_d);
    check($sformatf("err e=%0d tot=%0d", e, tot), out_err, exp_err);
    check($sformatf("n e=%0d tot=%0d", e, tot), out_n, n);
    check("busy_in_hold", busy, 1);
    if (hold > 0) begin
      d_s = out_d; n_s = out_n; err_s = out_err; stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if (i == 5) begin key_valid = 1'b1; key_e = 24'd5; key_tot = 24'd96; key_n = 24'd119; end
        if (i == 6) key_valid = 1'b0;
        @(posedge clk); #1;
        if (out_d !== d_s || out_n !== n_s || out_err !== err_s || out_valid !== 1'b1 ||
            key_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
      end
      check("backpressure_stable", stable, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("key_ready_rise", key_ready, 1);
    check("busy_drop", busy, 0);
  endtask

  initial begin
    logic [W-1:0] re, rt, rn;
    #12;
    check("rst_key_ready", key_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_d", out_d, 0);
    check("rst_out_n", out_n, 0);
    check("rst_out_err", out_err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    run_key(24'd17,   24'd3120, 24'd3233, 0);
    run_key(24'd7,    24'd40,   24'd55,   0);
    run_key(24'd3,    24'd3120, 24'd3233, 0);
    run_key(24'd0,    24'd3120, 24'd3233, 0);
    run_key(24'd1,    24'd3120, 24'd3233, 0);
    run_key(24'd3137, 24'd3120, 24'd3233, 0);
    run_key(24'd5,    24'd1,    24'd6,    0);
    run_key(24'd17,   24'd3120, 24'd3233, 20);

    // abort mid-division; out_d/out_n still hold the previous result before reset hits
    wait_ready();
    key_e = 24'd17; key_tot = 24'd3120; key_n = 24'd3233; key_valid = 1'b1;
    @(posedge clk); #1; key_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    check("abort_key_ready", key_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_d", out_d, 0);
    check("abort_out_n", out_n, 0);
    check("abort_out_err", out_err, 0);
    check("abort_busy", busy, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    run_key(24'd7, 24'd40, 24'd55, 0);

    for (int k = 0; k < 12; k++) begin
      rt = W'($urandom_range(2, (1 << W) - 1));
      if ($urandom_range(0, 3) == 0) re = W'($urandom_range(int'(rt), (1 << W) - 1));
      else re = W'($urandom_range(1, int'(rt) - 1 > 0 ? int'(rt) - 1 : 1));
      rn = W'($urandom);
      run_key(re, rt, rn, (k % 4 == 0) ? int'($urandom_range(1, 8)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rsa_priv_key_gen.md
Name: rsa_priv_key_gen

Overview:
- Consumer end of the key generator. Accepts one public key bundle (e, totient, n) over a valid/ready handshake.
- Computes the private exponent d = e^-1 mod totient with an iterative extended Euclidean algorithm.
- Presents (d, n) or an error flag to the decryption datapath over a second valid/ready handshake.
- Sits between the key generator and the modular-exponentiation decryptor.

Parameters:
- W, 24, width of e, totient, n and d.
- CNT_W, 6, width of the Euclid iteration counter; bounds iterations to 2^CNT_W-1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  key bundle on key_e/key_tot/key_n is valid
- key_ready  out  1  block can accept a bundle
- key_e  in  W  public exponent
- key_tot  in  W  totient (p-1)(q-1)
- key_n  in  W  modulus p*q
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_d  out  W  private exponent
- out_n  out  W  modulus passed through
- out_err  out  1  no inverse exists (gcd != 1, e==0, tot<2) or iteration bound hit
- busy  out  1  computation in progress

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: key_ready=1, out_valid=0, out_d=0, out_n=0, out_err=0, busy=0, FSM=IDLE. Reset asserted mid-computation aborts immediately; no partial result is ever presented.
- Input handshake: a transfer occurs on a cycle with key_valid&&key_ready. key_ready=1 only in IDLE. Bundle fields are registered on transfer; inputs are not sampled afterwards.
- Working registers:
  - r0,r1 are W-bit unsigned.
  - t0,t1 are W+1-bit signed; all t arithmetic is two's-complement modulo 2^(W+1). This is exact because |t| <= totient.
  - qt is a W-bit quotient.
- FSM states:
  - IDLE: on handshake set r0=tot, r1=e, t0=0, t1=1, iter=0, busy=1.
    - tot<2 or e==0: go to FIN with err.
    - Otherwise: go to CHECK.
  - CHECK:
    - r1==0: go to FIN.
    - iter==all-ones: err, go to FIN.
    - Otherwise: start the divider (r0/r1), go to DIV.
  - DIV: wait for div_done. The divider takes exactly W cycles after start.
  - UPD: one cycle.
    - (r0,r1) <= (r1, div remainder)
    - (t0,t1) <= (t1, t0 - qt*t1) truncated to W+1 bits
    - iter++, then go to CHECK.
  - FIN: one cycle.
    - r0!=1 or err: out_err=1, out_d=0.
    - Otherwise: out_d = t0<0 ? t0+tot : t0 (W bits); out_err=0.
    - In both cases out_n=n, out_valid=1, go to HOLD.
  - HOLD: out_* held stable while out_valid&&!out_ready. On out_ready go to IDLE; out_valid and busy drop next cycle, key_ready rises next cycle.
- e>tot is legal: the first iteration yields qt=0 and swaps the operands.
- e==1 gives d=1 after one iteration.
- Latency: 1 cycle (IDLE) + per iteration 1 (CHECK) + W+1 (DIV incl. start) + 1 (UPD), + 1 (final CHECK) + 1 (FIN) to out_valid. Example: 17/3120 has 4 iterations, 4*(W+3)+3 = 111 cycles with W=24.
- Throughput: one key in flight at a time. Back-to-back keys need at least one IDLE cycle between them.

Decomposition:
- Shared package rsa_pkg:
  - W default constant
  - FSM state encoding (IDLE, CHECK, DIV, UPD, FIN, HOLD, 3 bits)
  - key bundle field widths, reused by the generator and the decryptor
- One sub-module: rsa_div_seq, a restoring divider.
  - Ports: clk, rst_n, start, dividend[W], divisor[W], quotient[W], remainder[W], done.
  - W cycles per division, one quotient bit per cycle.
  - done is a one-cycle pulse; divisor is never 0 by construction.

Test Plan:
- Nominal: e=17, tot=3120, n=3233 -> out_d=2753, out_n=3233, out_err=0; out_valid 111 cycles after the handshake at W=24.
- Small key: e=7, tot=40, n=55 -> out_d=23, out_err=0.
- Non-coprime key: e=3, tot=3120 -> out_err=1, out_d=0. Separately, e=0 -> out_err=1 within 2 cycles of the handshake.
- Edge exponent: e=1, tot=3120 -> out_d=1. Also e=3137 (>tot, same as 17 mod 3120) -> out_d=2753.
- Backpressure: hold out_ready=0 for 20 cycles -> out_d/out_n/out_err stable and key_ready=0 throughout. A key_valid pulse during this window is not accepted; release -> key_ready=1 the following cycle.
- Reset abort: assert rst_n=0 during DIV of the nominal key -> all outputs return to reset values asynchronously. After release, a new key e=7, tot=40 -> out_d=23.
